// File: rtl/dcache_fill_unit.sv
// Line-fill engine: one bus read per miss, beats assembled into a full line, single-cycle SRAM write.
// Optional macro DCACHE_FILL_CWF_EN selects critical-word-first (wrap-order) beat placement.
`timescale 1ns/1ps
module dcache_fill_unit #(
  parameter int WIDTH        = 512,
  parameter int WORD_SIZE    = 64,
  parameter int LOG_NUM_ROWS = 9,
  parameter int ADDR_WIDTH   = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  output logic                    bus_req_valid,
  input  logic                    bus_req_ready,
  output logic [ADDR_WIDTH-1:0]   bus_req_addr,
  input  logic                    bus_resp_valid,
  input  logic [WORD_SIZE-1:0]    bus_resp_data,
  output logic [LOG_NUM_ROWS-1:0] writeAddr,
  output logic [WIDTH-1:0]        writeData,
  output logic [WIDTH/WORD_SIZE-1:0] writeEnable,
  output logic                    crit_valid,
  output logic [WORD_SIZE-1:0]    crit_word,
  output logic                    fill_done
);

  localparam int BEATS     = WIDTH / WORD_SIZE;
  localparam int OFF_BITS  = $clog2(WIDTH / 8);
  localparam int WOFF_BITS = $clog2(BEATS);
  localparam int WB_BITS   = $clog2(WORD_SIZE / 8);
`ifdef DCACHE_FILL_CWF_EN
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~((ADDR_WIDTH'(1) << WB_BITS) - ADDR_WIDTH'(1));
`else
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~((ADDR_WIDTH'(1) << OFF_BITS) - ADDR_WIDTH'(1));
`endif

  typedef enum logic [1:0] {IDLE, REQ, RECV, WRITE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LOG_NUM_ROWS-1:0] row_q, row_d;
  logic [WOFF_BITS-1:0]    cword_q, cword_d;
  logic [WOFF_BITS-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]        line_q, line_d;
  logic                    crit_valid_q, crit_valid_d;
  logic [WORD_SIZE-1:0]    crit_word_q, crit_word_d;
  logic [WOFF_BITS-1:0]    slot;

  // Word slot for the incoming beat; with wrap order the memory starts at the critical word.
`ifdef DCACHE_FILL_CWF_EN
  assign slot = cword_q + cnt_q;
`else
  assign slot = cnt_q;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    row_d        = row_q;
    cword_d      = cword_q;
    cnt_d        = cnt_q;
    line_d       = line_q;
    crit_valid_d = 1'b0;
    crit_word_d  = crit_word_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          row_d   = req_addr[OFF_BITS +: LOG_NUM_ROWS];
          cword_d = req_addr[WB_BITS +: WOFF_BITS];
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus_req_ready) begin
          cnt_d   = '0;
          state_d = RECV;
        end
      end
      RECV: begin
        if (bus_resp_valid) begin
          line_d[slot*WORD_SIZE +: WORD_SIZE] = bus_resp_data;
          cnt_d = cnt_q + WOFF_BITS'(1);
          if (slot == cword_q) begin
            crit_valid_d = 1'b1;
            crit_word_d  = bus_resp_data;
          end
          if (cnt_q == WOFF_BITS'(BEATS - 1)) state_d = WRITE;
        end
      end
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset also clears the line buffer so an aborted fill leaves nothing behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      row_q        <= '0;
      cword_q      <= '0;
      cnt_q        <= '0;
      line_q       <= '0;
      crit_valid_q <= 1'b0;
      crit_word_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      row_q        <= row_d;
      cword_q      <= cword_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      crit_valid_q <= crit_valid_d;
      crit_word_q  <= crit_word_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign bus_req_valid = (state_q == REQ);
  assign bus_req_addr  = addr_q & ALIGN_MASK;
  assign fill_done     = (state_q == WRITE);
  assign writeEnable   = (state_q == WRITE) ? '1 : '0;
  assign writeAddr     = row_q;
  assign writeData     = line_q;
  assign crit_valid    = crit_valid_q;
  assign crit_word     = crit_word_q;

endmodule

// File: tb/tb_dcache_fill_unit.sv
// Scoreboard bench for dcache_fill_unit: stimulus pushes expected bus/crit/fill responses, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_dcache_fill_unit;
  localparam int WIDTH = 512, WORD_SIZE = 64, LOG_NUM_ROWS = 9, ADDR_WIDTH = 64;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    req_valid = 1'b0;
  logic                    req_ready;
  logic [ADDR_WIDTH-1:0]   req_addr = '0;
  logic                    bus_req_valid;
  logic                    bus_req_ready = 1'b0;
  logic [ADDR_WIDTH-1:0]   bus_req_addr;
  logic                    bus_resp_valid = 1'b0;
  logic [WORD_SIZE-1:0]    bus_resp_data = '0;
  logic [LOG_NUM_ROWS-1:0] writeAddr;
  logic [WIDTH-1:0]        writeData;
  logic [7:0]              writeEnable;
  logic                    crit_valid;
  logic [WORD_SIZE-1:0]    crit_word;
  logic                    fill_done;

  dcache_fill_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_addr(bus_req_addr),
    .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
    .writeAddr(writeAddr), .writeData(writeData), .writeEnable(writeEnable),
    .crit_valid(crit_valid), .crit_word(crit_word), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0, crit_cyc = 0, fill_cyc = 0;

  logic [63:0]  exp_bus_q[$];
  logic [63:0]  exp_crit_q[$];
  logic [8:0]   exp_row_q[$];
  logic [511:0] exp_line_q[$];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [511:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compares every DUT response against the queued expectations and protocol invariants.
  initial begin : monitor
    logic busy, prev_fill, prev_stall;
    logic [63:0] prev_addr;
    busy = 1'b0; prev_fill = 1'b0; prev_stall = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clk);
      check("write_enable", writeEnable, fill_done ? 8'hFF : 8'h00);
      if (busy) check("req_ready_busy", req_ready, 1'b0);
      if (prev_fill) check("req_ready_after_write", req_ready, 1'b1);
      if (prev_stall) begin
        check("bus_req_valid_hold", bus_req_valid, 1'b1);
        check("bus_req_addr_hold", bus_req_addr, prev_addr);
      end
      if (bus_req_valid && bus_req_ready) begin
        if (exp_bus_q.size() == 0) unexpected("bus_req", bus_req_addr);
        else check("bus_req_addr", bus_req_addr, exp_bus_q.pop_front());
      end
      if (crit_valid) begin
        crit_cyc = cyc;
        if (exp_crit_q.size() == 0) unexpected("crit_word", crit_word);
        else check("crit_word", crit_word, exp_crit_q.pop_front());
      end
      if (fill_done) begin
        fill_cyc = cyc;
        if (exp_row_q.size() == 0) unexpected("fill_done", writeAddr);
        else begin
          check("write_addr", writeAddr, exp_row_q.pop_front());
          check("write_data", writeData, exp_line_q.pop_front());
        end
      end
      prev_fill  = fill_done && !reset;
      prev_stall = bus_req_valid && !bus_req_ready && !reset;
      prev_addr  = bus_req_addr;
      if (reset) busy = 1'b0;
      else if (req_valid && req_ready) begin
        busy = 1'b1;
        acc_cyc = cyc;
      end else if (fill_done) busy = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_req(input logic [63:0] a, input bit keep);
    req_addr  = a;
    req_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (req_ready) begin
        tick();
        if (!keep) req_valid = 1'b0;
        return;
      end
      tick();
    end
    req_valid = 1'b0;
    unexpected("req_accept_timeout", a);
  endtask

  task automatic serve_bus(input int stall);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus_req_valid) seen = 1'b1;
      else tick();
    end
    if (!seen) begin
      unexpected("bus_req_timeout", 0);
      return;
    end
    repeat (stall) tick();
    bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0;
  endtask

  task automatic send_beats(input logic [63:0] base, input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      bus_resp_valid = 1'b1;
      bus_resp_data  = base + 64'(k);
      tick();
      bus_resp_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  // Reference placement model: which slot each beat lands in and which beat is critical.
  task automatic push_fill(input logic [63:0] a, input logic [63:0] base, input int n);
    logic [511:0] line;
    logic [2:0] cw, w;
    line = '0;
    cw = a[5:3];
`ifdef DCACHE_FILL_CWF_EN
    exp_bus_q.push_back(a & ~64'h7);
`else
    exp_bus_q.push_back(a & ~64'h3F);
`endif
    for (int k = 0; k < n; k++) begin
`ifdef DCACHE_FILL_CWF_EN
      w = cw + 3'(k);
`else
      w = 3'(k);
`endif
      line[w*64 +: 64] = base + 64'(k);
      if (w == cw) exp_crit_q.push_back(base + 64'(k));
    end
    if (n == 8) begin
      exp_row_q.push_back(a[14:6]);
      exp_line_q.push_back(line);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_bus_req_valid", bus_req_valid, 1'b0);
    check("rst_write_enable", writeEnable, 8'h00);
    check("rst_crit_valid", crit_valid, 1'b0);
    check("rst_fill_done", fill_done, 1'b0);
    check("rst_write_addr", writeAddr, 9'h000);
    check("rst_write_data", writeData, 512'h0);
    check("rst_bus_req_addr", bus_req_addr, 64'h0);
    check("rst_crit_word", crit_word, 64'h0);
  endtask

  initial begin : stim
    logic [511:0] line;
    int first_fill;
    reset = 1'b1;
    repeat (3) tick();
    check_reset_outputs();
    reset = 1'b0;
    tick();

    // Basic fill with hand-computed results
`ifdef DCACHE_FILL_CWF_EN
    push_fill(64'h1_2348, 64'h100, 8);
`else
    exp_bus_q.push_back(64'h1_2340);
    exp_crit_q.push_back(64'h101);
    exp_row_q.push_back(9'h08D);
    line = '0;
    for (int i = 0; i < 8; i++) line[i*64 +: 64] = 64'h100 + 64'(i);
    exp_line_q.push_back(line);
`endif
    issue_req(64'h1_2348, 1'b0);
    serve_bus(0);
    send_beats(64'h100, 8, 0);
    repeat (2) tick();
`ifdef DCACHE_FILL_CWF_EN
    check("crit_latency", 32'(crit_cyc - acc_cyc), 32'd3);
`else
    check("crit_latency", 32'(crit_cyc - acc_cyc), 32'd4);
`endif
    check("write_latency", 32'(fill_cyc - acc_cyc), 32'd10);

    // Request at word 7 of row 1
    line = '0;
`ifdef DCACHE_FILL_CWF_EN
    exp_bus_q.push_back(64'h78);
    exp_crit_q.push_back(64'hA0);
    line[7*64 +: 64] = 64'hA0;
    for (int j = 0; j < 7; j++) line[j*64 +: 64] = 64'hA1 + 64'(j);
`else
    exp_bus_q.push_back(64'h40);
    exp_crit_q.push_back(64'hA7);
    for (int i = 0; i < 8; i++) line[i*64 +: 64] = 64'hA0 + 64'(i);
`endif
    exp_row_q.push_back(9'h001);
    exp_line_q.push_back(line);
    issue_req(64'h78, 1'b0);
    serve_bus(0);
    send_beats(64'hA0, 8, 0);
    repeat (2) tick();

    // Bus request stall and gapped beats
    push_fill(64'h5A10, 64'h200, 8);
    issue_req(64'h5A10, 1'b0);
    serve_bus(5);
    send_beats(64'h200, 8, 2);
    repeat (3) tick();

    // Reset in the middle of a fill, then stray beats, then a fresh fill
    push_fill(64'h2_0038, 64'h300, 4);
    issue_req(64'h2_0038, 1'b0);
    serve_bus(0);
    send_beats(64'h300, 4, 0);
    reset = 1'b1;
    tick();
    check_reset_outputs();
    tick();
    reset = 1'b0;
    send_beats(64'h400, 4, 0);
    check("stray_req_ready", req_ready, 1'b1);
    push_fill(64'h40, 64'h500, 8);
    issue_req(64'h40, 1'b0);
    serve_bus(0);
    send_beats(64'h500, 8, 0);
    repeat (2) tick();

    // Back-to-back requests with req_valid held high
    push_fill(64'h1000, 64'h600, 8);
    issue_req(64'h1000, 1'b1);
    req_addr = 64'h2_0FC8;
    serve_bus(0);
    send_beats(64'h600, 8, 1);
    push_fill(64'h2_0FC8, 64'h700, 8);
    first_fill = fill_cyc;
    serve_bus(0);
    req_valid = 1'b0;
    check("second_accept_cycle", 32'(acc_cyc - first_fill), 32'd1);
    send_beats(64'h700, 8, 0);
    repeat (4) tick();

    check("bus_queue_empty", 32'(exp_bus_q.size()), 32'd0);
    check("crit_queue_empty", 32'(exp_crit_q.size()), 32'd0);
    check("fill_queue_empty", 32'(exp_row_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_fill_unit.md
Name: dcache_fill_unit

Overview:
- Line-fill engine directly upstream of the dcache data SRAM write port.
- Takes a miss request (byte address), issues one line read on the memory bus and collects WIDTH/WORD_SIZE beats of WORD_SIZE bits.
- Writes the assembled line into the SRAM in a single cycle with all word enables set, and reports the critical word early to the load pipeline.

Parameters:
- WIDTH, 512, line width in bits; matches the SRAM row width.
- WORD_SIZE, 64, bus beat width and SRAM write-enable granularity.
- LOG_NUM_ROWS, 9, SRAM row index width.
- ADDR_WIDTH, 64, byte address width.
- Derived (localparam): BEATS = WIDTH/WORD_SIZE (8); OFF_BITS = log2(WIDTH/8) (6); WOFF_BITS = log2(BEATS) (3).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  miss request valid
- req_ready  out  1  unit idle, able to accept a request
- req_addr  in  ADDR_WIDTH  miss byte address
- bus_req_valid  out  1  memory read request valid
- bus_req_ready  in  1  memory accepts the request
- bus_req_addr  out  ADDR_WIDTH  memory read address
- bus_resp_valid  in  1  beat valid; no backpressure
- bus_resp_data  in  WORD_SIZE  beat data
- writeAddr  out  LOG_NUM_ROWS  SRAM row to write
- writeData  out  WIDTH  SRAM line data
- writeEnable  out  BEATS  per-word SRAM write enable
- crit_valid  out  1  one-cycle pulse: requested word available
- crit_word  out  WORD_SIZE  requested word; valid only with crit_valid
- fill_done  out  1  one-cycle pulse, coincident with the SRAM write cycle

Behaviour:
- Reset (synchronous, active-high; highest priority, including mid-fill):
  - Go to IDLE, clear beat counter and line buffer, discard any partial line.
  - Outputs after reset: req_ready=1; bus_req_valid=0; writeEnable=0; crit_valid=0; fill_done=0; writeAddr=0; writeData=0; bus_req_addr=0; crit_word=0.
- FSM states IDLE, REQ, RECV, WRITE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch req_addr; row = req_addr[OFF_BITS +: LOG_NUM_ROWS]; cword = req_addr[3 +: WOFF_BITS] (8-byte words).
  - Then go to REQ.
- REQ:
  - bus_req_valid=1 and bus_req_addr held stable until bus_req_ready is sampled high; then go to RECV, beat counter = 0.
  - bus_req_ready in the same cycle bus_req_valid first rises is legal (one-cycle REQ).
- RECV:
  - Each cycle with bus_resp_valid: store the beat into word slot w (see Optional Feature for w), then increment the beat counter.
  - Counter width is WOFF_BITS. On acceptance of beat BEATS-1 (counter wraps to 0), go to WRITE.
  - Gaps between beats are allowed and of any length.
- WRITE (exactly one cycle):
  - writeEnable = all ones; writeAddr = latched row; writeData = assembled line; fill_done=1.
  - Next state IDLE.
  - writeEnable=0 in every other state.
- Critical word: crit_valid pulses the cycle after the beat with w == cword is accepted; crit_word = that beat.
- Bus response handling:
  - bus_resp_valid outside RECV (e.g. stale beats after a mid-fill reset) is ignored.
  - At most one fill is outstanding; req_valid is ignored while req_ready=0.
- Latency, back-to-back bus, BEATS=8:
  - req accepted in cycle 0; REQ in cycle 1; beats in cycles 2–9; WRITE in cycle 10; req_ready=1 again in cycle 11.
- The SRAM reads one cycle after its write is issued; the load side must not read the row before fill_done+1.

Optional Feature:
- Macro DCACHE_FILL_CWF_EN (critical-word-first).
- Defined:
  - bus_req_addr = latched address with the low 3 bits zeroed (word-aligned).
  - The memory returns words in wrap order starting at cword.
  - Beat k is placed at w = (cword + k) mod BEATS.
  - crit_valid fires the cycle after the first beat.
- Undefined:
  - bus_req_addr = latched address with the low OFF_BITS bits zeroed (line-aligned).
  - Beat k is placed at w = k.
  - crit_valid fires the cycle after beat cword.

Test Plan:
- Basic fill, macro off: req_addr=0x1_2348, beats 0x100..0x107 back-to-back.
  - bus_req_addr=0x1_2340; row=0x08D; cword=1.
  - crit_valid in cycle 4 with crit_word=0x101.
  - WRITE cycle 10: writeAddr=0x08D, writeEnable=0xFF, writeData word i = 0x100+i, fill_done=1.
- Critical word first, macro on: req_addr=0x78, beats 0xA0..0xA7.
  - bus_req_addr=0x78.
  - crit_valid the cycle after the first beat, crit_word=0xA0.
  - Line words: word7=0xA0, word0=0xA1 … word6=0xA7.
- Stalls: bus_req_ready held low 5 cycles, then 2-cycle gaps between beats.
  - bus_req_valid and bus_req_addr stay stable while stalled.
  - Exactly one WRITE after the 8th beat; writeEnable=0 at all other times.
- Reset mid-fill: assert reset after beat 3, then send 4 stray beats, then a new request for 0x40.
  - Stray beats are ignored.
  - The new fill writes row 1 containing only the new beats; no fill_done for the aborted fill.
- Back-to-back requests: req_valid held high across two fills.
  - The second request is accepted only in the cycle after WRITE.
  - No beat is shared between fills; req_ready=0 from acceptance through WRITE.
